// File: rtl/pc_ctrl.sv
// Pipeline front-end controller: PC write/next-PC, IF/ID and ID/EX control, memory-wait freeze.
// Optional performance counters are built only when PC_CTRL_PERF_EN is defined.
module pc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_branch_taken_i,
  input  logic [31:0] ex_branch_target_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  output logic        pc_write_o,
  output logic [31:0] pc_next_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        stall_all_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q;
  logic          mem_pend, load_use, hold;

  assign mem_pend = dmem_req_i & ~dmem_ack_i;
  assign load_use = ex_memread_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  assign hold     = ((state_q == RUN) && mem_pend) || ((state_q == MEM_WAIT) && !dmem_ack_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start_i) state_d = RUN;
      RUN:      if (mem_pend)      state_d = MEM_WAIT;
                else if (!start_i) state_d = IDLE;
      MEM_WAIT: if (dmem_ack_i) state_d = start_i ? RUN : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Freeze outranks branch, which outranks load-use; a frozen branch is re-presented on release.
  always_comb begin
    pc_write_o    = 1'b0;
    pc_next_o     = pc_i + 32'd4;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    stall_all_o   = 1'b0;
    if (state_q == IDLE) begin
      idex_bubble_o = 1'b1;
    end else if (hold) begin
      stall_all_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      pc_write_o    = 1'b1;
      pc_next_o     = ex_branch_target_i;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (load_use) begin
      idex_bubble_o = 1'b1;
    end else begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_q == RUN) && mem_pend)
      wait_cnt_d = CW'(1);
    else if ((state_q == MEM_WAIT) && !dmem_ack_i && (wait_cnt_q != '1))
      wait_cnt_d = wait_cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (hold && (wait_cnt_d >= CW'(MEM_TIMEOUT)))
        err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

`ifdef PC_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q != IDLE) && !pc_write_o && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ifid_flush_o && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: expected controls queued as stimulus is driven, compared mid-cycle.
module tb_pc_ctrl;

`ifdef PC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, ifid_write, ifid_flush, idex_bubble, stall_all}
  localparam logic [4:0] C_IDLE = 5'b00010;
  localparam logic [4:0] C_NORM = 5'b11000;
  localparam logic [4:0] C_LU   = 5'b00010;
  localparam logic [4:0] C_BR   = 5'b10110;
  localparam logic [4:0] C_MEM  = 5'b00001;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        ex_memread_i, ex_branch_taken_i;
  logic [31:0] ex_branch_target_i;
  logic        dmem_req_i, dmem_ack_i;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stall_all_o, err_o;
  logic [31:0] pc_next_o, stall_cnt_o, flush_cnt_o;

  pc_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .ex_branch_taken_i(ex_branch_taken_i), .ex_branch_target_i(ex_branch_target_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .pc_write_o(pc_write_o), .pc_next_o(pc_next_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o), .stall_all_o(stall_all_o),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic        err;
    logic [31:0] pcn;
    logic        run;
  } exp_t;

  exp_t        sb[$];
  string       sb_tag[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        exp_err  = 1'b0;
  logic [31:0] m_stall  = '0;
  logic [31:0] m_flush  = '0;
  exp_t        mon_e;
  string       mon_tag;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [4:0] ctrl_now();
    return {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, stall_all_o};
  endfunction

  // Counters seen mid-cycle reflect all earlier cycles since reset release.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      m_stall = '0;
      m_flush = '0;
    end else if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_tag = sb_tag.pop_front();
      check_eq({mon_tag, "_ctrl"}, 32'(ctrl_now()), 32'(mon_e.ctrl));
      check_eq({mon_tag, "_pcn"}, pc_next_o, mon_e.pcn);
      check_eq({mon_tag, "_err"}, 32'(err_o), 32'(mon_e.err));
      check_eq({mon_tag, "_stallcnt"}, stall_cnt_o, PERF ? m_stall : 32'd0);
      check_eq({mon_tag, "_flushcnt"}, flush_cnt_o, PERF ? m_flush : 32'd0);
      if (mon_e.run && !mon_e.ctrl[4]) m_stall = m_stall + 32'd1;
      if (mon_e.ctrl[2])               m_flush = m_flush + 32'd1;
    end
  end

  task automatic cyc(input string tag, input logic [4:0] ctrl, input logic run);
    exp_t e;
    e.ctrl = ctrl;
    e.err  = exp_err;
    e.pcn  = ctrl[2] ? ex_branch_target_i : pc_i + 32'd4;
    e.run  = run;
    sb.push_back(e);
    sb_tag.push_back(tag);
    @(posedge clk_i);
    #1;
    if (ctrl[4]) pc_i = e.pcn;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ctrl"}, 32'(ctrl_now()), 32'(C_IDLE));
    check_eq({tag, "_pcn"}, pc_next_o, pc_i + 32'd4);
    check_eq({tag, "_err"}, 32'(err_o), 32'd0);
    check_eq({tag, "_stallcnt"}, stall_cnt_o, 32'd0);
    check_eq({tag, "_flushcnt"}, flush_cnt_o, 32'd0);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; pc_i = '0;
    id_rs1_i = '0; id_rs2_i = '0; ex_rd_i = '0; ex_memread_i = 1'b0;
    ex_branch_taken_i = 1'b0; ex_branch_target_i = '0;
    dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_state("rst");
    rst_i = 1'b1;

    cyc("idle0", C_IDLE, 1'b0);
    cyc("idle1", C_IDLE, 1'b0);
    start_i = 1'b1;
    cyc("start", C_IDLE, 1'b0);
    for (int i = 0; i < 3; i++) cyc("run", C_NORM, 1'b1);

    ex_memread_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd3; id_rs2_i = 5'd5;
    cyc("lu", C_LU, 1'b1);
    ex_memread_i = 1'b0;
    cyc("lu_after", C_NORM, 1'b1);
    ex_memread_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    cyc("lu_x0", C_NORM, 1'b1);

    ex_rd_i = 5'd5; id_rs2_i = 5'd5;
    ex_branch_taken_i = 1'b1; ex_branch_target_i = 32'h40;
    cyc("br", C_BR, 1'b1);
    ex_branch_taken_i = 1'b0; ex_memread_i = 1'b0;
    cyc("br_after", C_NORM, 1'b1);

    dmem_req_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc("mem", C_MEM, 1'b1);
    dmem_ack_i = 1'b1;
    cyc("mem_ack", C_NORM, 1'b1);
    dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
    cyc("mem_after", C_NORM, 1'b1);

    dmem_req_i = 1'b1; ex_branch_taken_i = 1'b1; ex_branch_target_i = 32'h80;
    for (int i = 0; i < 2; i++) cyc("mem_br", C_MEM, 1'b1);
    dmem_ack_i = 1'b1;
    cyc("mem_br_rel", C_BR, 1'b1);
    dmem_req_i = 1'b0; dmem_ack_i = 1'b0; ex_branch_taken_i = 1'b0;
    cyc("mem_br_after", C_NORM, 1'b1);

    dmem_req_i = 1'b1; start_i = 1'b0;
    cyc("stop_mem", C_MEM, 1'b1);
    cyc("stop_wait", C_MEM, 1'b1);
    dmem_ack_i = 1'b1;
    cyc("stop_ack", C_NORM, 1'b1);
    dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
    cyc("stop_idle", C_IDLE, 1'b0);
    start_i = 1'b1;
    cyc("restart", C_IDLE, 1'b0);
    cyc("restart_run", C_NORM, 1'b1);

    dmem_req_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc("tmo", C_MEM, 1'b1);
      if (i == 8) exp_err = 1'b1;
    end
    dmem_ack_i = 1'b1;
    cyc("tmo_ack", C_NORM, 1'b1);
    dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
    cyc("tmo_after", C_NORM, 1'b1);

    #2 rst_i = 1'b0;
    #1 check_reset_state("rst_mid");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    exp_err = 1'b0;

    cyc("rst2_idle", C_IDLE, 1'b0);
    pc_i = 32'hFFFF_FFFC;
    cyc("wrap", C_NORM, 1'b1);
    cyc("wrap_after", C_NORM, 1'b1);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
